// File: rtl/xbar_cfg_loader_if.sv
// Host/chain signal bundle for the crossbar configuration loader.
//   start, abort       : load request / synchronous abort (host -> loader)
//   din, din_valid     : configuration word and its valid (host -> loader)
//   din_ready          : loader accepts din this cycle (loader -> host)
//   se, sin            : shift enable / serial data to chain head (loader -> chain)
//   sout               : serial data from chain tail (chain -> loader)
//   busy, done         : status and end-of-load pulse (loader -> host)
//   dout, dout_valid   : readback word and its 1-cycle strobe (loader -> host)
// The slave modport is the loader's view; master is the host/chain side.
interface xbar_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              se;
    logic              sin;
    logic              sout;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;

    modport slave (
        input  start, abort, din, din_valid, sout,
        output din_ready, se, sin, busy, done, dout, dout_valid
    );

    modport master (
        output start, abort, din, din_valid, sout,
        input  din_ready, se, sin, busy, done, dout, dout_valid
    );
endinterface

// File: rtl/xbar_cfg_loader.sv
// Writer side of the crossbar configuration scan chain.
// Takes WORD_W-bit words from the host over a valid/ready handshake and
// serialises them LSB-first onto the chain (se/sin) until exactly CHAIN_LEN
// bits have been shifted; the last word may be partial (upper bits dropped).
//
// Ports:
//   clk   : system clock, all state changes on its rising edge
//   rstn  : asynchronous active-low reset
//   bus   : xbar_cfg_loader_if.slave (handshake, chain and readback signals)
//
// Optional build macro XBAR_CFG_READBACK_EN: when defined, the bit leaving the
// chain tail (sout) on every shift cycle is packed LSB-first into a readback
// word, presented on dout with a 1-cycle dout_valid after each word. When not
// defined, dout and dout_valid are tied to 0 and sout is ignored.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | din_ready high, waiting for the next word
// SHIFT | se high, one bit of the current word per cycle
// FIN   | done pulse, then back to IDLE
module xbar_cfg_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 160,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rstn,
    xbar_cfg_loader_if.slave bus
);
    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bits_left, bits_left_nxt;
    logic [WB_W-1:0]   word_bits, word_bits_nxt;
    logic [WORD_W-1:0] sreg, sreg_nxt;
    logic              accept;

    always_comb begin
        state_nxt     = state;
        bits_left_nxt = bits_left;
        word_bits_nxt = word_bits;
        sreg_nxt      = sreg;
        accept        = 1'b0;
        if (bus.abort) begin
            state_nxt     = IDLE;
            bits_left_nxt = '0;
            word_bits_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt     = LOAD;
                        bits_left_nxt = CNT_W'(CHAIN_LEN);
                    end
                end
                LOAD: begin
                    if (bus.din_valid && bus.din_ready) begin
                        accept        = 1'b1;
                        sreg_nxt      = bus.din;
                        word_bits_nxt = (bits_left >= CNT_W'(WORD_W)) ? WB_W'(WORD_W)
                                                                       : WB_W'(bits_left);
                        state_nxt     = SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_nxt = sreg >> 1;
                    if (word_bits != '0) word_bits_nxt = word_bits - WB_W'(1);
                    if (bits_left != '0) bits_left_nxt = bits_left - CNT_W'(1);
                    // Last bit of this word: either the whole chain is done or
                    // we return to LOAD for the next word.
                    if (word_bits <= WB_W'(1)) begin
                        state_nxt = (bits_left <= CNT_W'(1)) ? FIN : LOAD;
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so se/sin never glitch and
    // all drop asynchronously on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            bits_left     <= '0;
            word_bits     <= '0;
            sreg          <= '0;
            bus.din_ready <= 1'b0;
            bus.se        <= 1'b0;
            bus.sin       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            bits_left     <= bits_left_nxt;
            word_bits     <= word_bits_nxt;
            sreg          <= sreg_nxt;
            bus.din_ready <= (state_nxt == LOAD);
            bus.se        <= (state_nxt == SHIFT);
            bus.sin       <= (state_nxt == SHIFT) ? sreg_nxt[0] : 1'b0;
            bus.busy      <= (state_nxt != IDLE);
            bus.done      <= (state_nxt == FIN);
        end
    end

`ifdef XBAR_CFG_READBACK_EN
    logic [WORD_W-1:0] rb_word;
    logic [WB_W-1:0]   rb_idx;

    // Readback word boundaries coincide with the shifted-word boundaries, so
    // the word is flushed on the same cycle the loader shifts its last bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rb_word        <= '0;
            rb_idx         <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            if (bus.abort || accept) begin
                rb_word <= '0;
                rb_idx  <= '0;
            end else if (state == SHIFT) begin
                rb_word <= rb_word | (WORD_W'(bus.sout) << rb_idx);
                rb_idx  <= rb_idx + WB_W'(1);
                if (word_bits <= WB_W'(1)) begin
                    bus.dout       <= rb_word | (WORD_W'(bus.sout) << rb_idx);
                    bus.dout_valid <= 1'b1;
                end
            end
        end
    end
`else
    wire unused_sout = bus.sout;

    assign bus.dout       = '0;
    assign bus.dout_valid = 1'b0;
`endif

endmodule
